msad_mv_select: RTL

- Sits directly downstream of the motion-estimation datapath. Consumes the per-batch minimum SAD and its in-batch index, one batch per valid cycle.
- Tracks the running minimum across all batches of one current block's search window.
- Converts the winning batch/index position into a signed motion vector.
- Presents {SAD, MV} to the bitstream/writeback stage through a one-entry valid/ready output register.

---
 rtl/msad_mv_select.sv | 90 +++++++++
 1 files changed

// File: rtl/msad_mv_select.sv
// msad_mv_select: tracks the minimum SAD across one block's batches and emits {SAD, MV}
// through a one-entry valid/ready result register.
module msad_mv_select #(
  parameter int PIXELS_IN_BATCH = 16,
  parameter int NUM_COLS        = 16,
  parameter int SAD_BIT_WIDTH   = 14,
  parameter int MV_BIT_WIDTH    = 6,
  parameter int OFFSET_X        = 8,
  parameter int OFFSET_Y        = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           msad_valid,
  input  logic [SAD_BIT_WIDTH-1:0]       MSAD_interim,
  input  logic [3:0]                     MSAD_index_interim,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SAD_BIT_WIDTH-1:0]       best_sad,
  output logic signed [MV_BIT_WIDTH-1:0] mv_x,
  output logic signed [MV_BIT_WIDTH-1:0] mv_y,
  output logic                           overflow,
  output logic                           busy
);
  localparam int CW = NUM_COLS > 1 ? $clog2(NUM_COLS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_COLS - 1);
  logic                     r_s1_valid;
  logic [SAD_BIT_WIDTH-1:0] r_s1_sad;
  logic [3:0]               r_s1_idx;
  logic [CW-1:0]            r_col_cnt;
  logic [SAD_BIT_WIDTH-1:0] r_run_sad;
  logic [CW-1:0]            r_run_col;
  logic [3:0]               r_run_row;
  logic                     w_take;
  logic                     w_done;
  logic [SAD_BIT_WIDTH-1:0] w_fin_sad;
  logic [CW-1:0]            w_fin_col;
  logic [3:0]               w_fin_row;
  // The first batch of a block always loads, so nothing carries over between blocks.
  always_comb begin
    w_take    = (r_col_cnt == '0) || (r_s1_sad < r_run_sad);
    w_done    = r_s1_valid && (r_col_cnt == LAST);
    w_fin_sad = w_take ? r_s1_sad : r_run_sad;
    w_fin_col = w_take ? r_col_cnt : r_run_col;
    w_fin_row = w_take ? r_s1_idx : r_run_row;
  end
  assign busy = (r_col_cnt != '0) || r_s1_valid;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sad   <= '0;
      r_s1_idx   <= '0;
      r_col_cnt  <= '0;
      r_run_sad  <= '1;
      r_run_col  <= '0;
      r_run_row  <= '0;
    end else begin
      r_s1_valid <= msad_valid;
      r_s1_sad   <= MSAD_interim;
      r_s1_idx   <= MSAD_index_interim;
      if (r_s1_valid) begin
        r_col_cnt <= (r_col_cnt == LAST) ? '0 : r_col_cnt + 1'b1;
        r_run_sad <= w_fin_sad;
        r_run_col <= w_fin_col;
        r_run_row <= w_fin_row;
      end
    end
  end
  // A completion while the previous result is still unconsumed overwrites it and flags overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      best_sad  <= '0;
      mv_x      <= '0;
      mv_y      <= '0;
      overflow  <= 1'b0;
    end else if (w_done) begin
      out_valid <= 1'b1;
      best_sad  <= w_fin_sad;
      mv_x      <= MV_BIT_WIDTH'(w_fin_col) - MV_BIT_WIDTH'(OFFSET_X);
      mv_y      <= MV_BIT_WIDTH'(w_fin_row) - MV_BIT_WIDTH'(OFFSET_Y);
      overflow  <= overflow | (out_valid & ~out_ready);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst && msad_valid)
      assert (32'(MSAD_index_interim) < PIXELS_IN_BATCH);
  end
endmodule
